// File: rtl/vector_lane_dispatcher.sv
`timescale 1ns/1ps
// vector_lane_dispatcher
//
// Captures two V-element source vectors, a scalar and an operation type, then
// issues the operands to a LANES-wide vector ALU over BEATS = ceil(V/LANES)
// beats with a valid/ready handshake. Elements are assigned to lanes in either
// blocked order (e = l*BEATS + b) or interleaved order (e = b*LANES + l). Lanes
// whose element index falls past V are masked and drive zero.
//
// Ports
//   CLK, RST        clock (rising edge) and synchronous active-high reset
//   start_i         dispatch request, only honoured in IDLE
//   OpType_i        bit0: 1 = vector-vector, 0 = vector-scalar
//                   bit1: 0 = blocked order, 1 = interleaved order
//   RD1_VEC_i       source vector A (V x N)
//   RD2_VEC_i       source vector B (V x N)
//   Scalar_i        scalar used as operand B in vector-scalar mode
//   ready_i         downstream accepts the presented beat
//   Vec_A_o/Vec_B_o lane operands (LANES x N)
//   lane_valid_o    per-lane element-present mask
//   beat_o          current beat index
//   valid_o         beat presented (ISSUE)
//   busy_o          high in ISSUE and DONE
//   done_o          one-cycle pulse after the final beat is accepted
module vector_lane_dispatcher #(
    parameter int N      = 32,
    parameter int V      = 20,
    parameter int LANES  = 4,
    localparam int BEATS = (V + LANES - 1) / LANES,
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start_i,
    input  logic [1:0]              OpType_i,
    input  logic [V-1:0][N-1:0]     RD1_VEC_i,
    input  logic [V-1:0][N-1:0]     RD2_VEC_i,
    input  logic [N-1:0]            Scalar_i,
    input  logic                    ready_i,
    output logic [LANES-1:0][N-1:0] Vec_A_o,
    output logic [LANES-1:0][N-1:0] Vec_B_o,
    output logic [LANES-1:0]        lane_valid_o,
    output logic [BW-1:0]           beat_o,
    output logic                    valid_o,
    output logic                    busy_o,
    output logic                    done_o
);
    // Element index width: wide enough for every index the lane grid can
    // form (up to LANES*BEATS-1), so the out-of-range test never wraps.
    localparam int EW = $clog2(LANES * BEATS + 1);
    localparam int IW = (V > 1) ? $clog2(V) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [V-1:0][N-1:0] a_cap_q, a_cap_d;
    logic [V-1:0][N-1:0] b_cap_q, b_cap_d;
    logic [N-1:0]        scalar_cap_q, scalar_cap_d;
    logic [1:0]          op_cap_q, op_cap_d;

    // State and capture registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            a_cap_q      <= '0;
            b_cap_q      <= '0;
            scalar_cap_q <= '0;
            op_cap_q     <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            a_cap_q      <= a_cap_d;
            b_cap_q      <= b_cap_d;
            scalar_cap_q <= scalar_cap_d;
            op_cap_q     <= op_cap_d;
        end
    end

    // Next-state and capture logic
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        a_cap_d      = a_cap_q;
        b_cap_d      = b_cap_q;
        scalar_cap_d = scalar_cap_q;
        op_cap_d     = op_cap_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    a_cap_d      = RD1_VEC_i;
                    b_cap_d      = RD2_VEC_i;
                    scalar_cap_d = Scalar_i;
                    op_cap_d     = OpType_i;
                    beat_d       = '0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ready_i) begin
                    if (beat_q == LAST_BEAT) begin
                        // Park the beat counter at zero so beat_o reads 0 later
                        beat_d  = '0;
                        state_d = ST_DONE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Control outputs
    always_comb begin
        valid_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        beat_o  = '0;
        case (state_q)
            ST_ISSUE: begin
                valid_o = 1'b1;
                busy_o  = 1'b1;
                beat_o  = beat_q;
            end
            ST_DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Per-lane element selection. Out-of-range lanes use index 0 for the read
    // so the mux never addresses past the captured vector, then get zeroed.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [EW-1:0] elem_idx;
        logic          elem_ok;
        logic [IW-1:0] sel_idx;
        logic          lane_on;

        assign elem_idx = op_cap_q[1] ? (EW'(beat_q) * EW'(LANES) + EW'(gi))
                                      : (EW'(gi) * EW'(BEATS) + EW'(beat_q));
        assign elem_ok  = (elem_idx < EW'(V));
        assign sel_idx  = elem_ok ? IW'(elem_idx) : '0;
        assign lane_on  = valid_o && elem_ok;

        assign lane_valid_o[gi] = lane_on;
        assign Vec_A_o[gi]      = lane_on ? a_cap_q[sel_idx] : '0;
        assign Vec_B_o[gi]      = !lane_on    ? '0 :
                                  op_cap_q[0] ? b_cap_q[sel_idx] : scalar_cap_q;
    end

endmodule

// File: tb/tb_vector_lane_dispatcher.sv
`timescale 1ns/1ps
// Bench for vector_lane_dispatcher: three instances (20x4, 10x4, 20x20),
// a table of spot-check vectors, a scoreboard on the 20x4 instance and
// hand-written sequences for backpressure, reset abort and single-beat mode.
module tb_vector_lane_dispatcher;

    logic clk;
    logic RST;
    logic ready;
    logic [19:0][31:0] rd1, rd2;
    logic [31:0] scalar;

    // Instance 0: V=20, LANES=4 (5 beats)
    logic start0;
    logic [1:0] op0;
    logic [3:0][31:0] a0, b0;
    logic [3:0] lv0;
    logic [2:0] beat0;
    logic valid0, busy0, done0;

    // Instance 1: V=10, LANES=4 (3 beats)
    logic start1;
    logic [1:0] op1;
    logic [3:0][31:0] a1, b1;
    logic [3:0] lv1;
    logic [1:0] beat1;
    logic valid1, busy1, done1;

    // Instance 2: V=20, LANES=20 (1 beat)
    logic start2;
    logic [1:0] op2;
    logic [19:0][31:0] a2, b2;
    logic [19:0] lv2;
    logic [0:0] beat2;
    logic valid2, busy2, done2;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    vector_lane_dispatcher #(.N(32), .V(20), .LANES(4)) u0 (
        .CLK(clk), .RST(RST), .start_i(start0), .OpType_i(op0),
        .RD1_VEC_i(rd1), .RD2_VEC_i(rd2), .Scalar_i(scalar), .ready_i(ready),
        .Vec_A_o(a0), .Vec_B_o(b0), .lane_valid_o(lv0), .beat_o(beat0),
        .valid_o(valid0), .busy_o(busy0), .done_o(done0)
    );

    vector_lane_dispatcher #(.N(32), .V(10), .LANES(4)) u1 (
        .CLK(clk), .RST(RST), .start_i(start1), .OpType_i(op1),
        .RD1_VEC_i(rd1[9:0]), .RD2_VEC_i(rd2[9:0]), .Scalar_i(scalar), .ready_i(ready),
        .Vec_A_o(a1), .Vec_B_o(b1), .lane_valid_o(lv1), .beat_o(beat1),
        .valid_o(valid1), .busy_o(busy1), .done_o(done1)
    );

    vector_lane_dispatcher #(.N(32), .V(20), .LANES(20)) u2 (
        .CLK(clk), .RST(RST), .start_i(start2), .OpType_i(op2),
        .RD1_VEC_i(rd1), .RD2_VEC_i(rd2), .Scalar_i(scalar), .ready_i(ready),
        .Vec_A_o(a2), .Vec_B_o(b2), .lane_valid_o(lv2), .beat_o(beat2),
        .valid_o(valid2), .busy_o(busy2), .done_o(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard for instance 0: one entry per expected beat
    typedef struct {
        logic [3:0][31:0] a;
        logic [3:0][31:0] b;
        logic [3:0]       lv;
        int               beat;
    } beat_t;
    beat_t sbq[$];

    task automatic push_expect0(input logic [1:0] op);
        beat_t ent;
        int e;
        for (int b = 0; b < 5; b++) begin
            for (int l = 0; l < 4; l++) begin
                e = op[1] ? (b * 4 + l) : (l * 5 + b);
                ent.a[l] = rd1[e];
                ent.b[l] = op[0] ? rd2[e] : scalar;
            end
            ent.lv   = 4'hF;
            ent.beat = b;
            sbq.push_back(ent);
        end
    endtask

    // Every presented beat is compared against the queue head; it is popped
    // only when accepted, so a held beat is rechecked each stalled cycle.
    always @(negedge clk) begin
        if (!RST && valid0) begin
            if (sbq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL u0_unexpected_beat: got beat %0d expected no beat", beat0);
            end else begin
                chk("u0_sb_a", 640'(a0), 640'(sbq[0].a));
                chk("u0_sb_b", 640'(b0), 640'(sbq[0].b));
                chk("u0_sb_lv", 640'(lv0), 640'(sbq[0].lv));
                chk("u0_sb_beat", 640'(beat0), 640'(sbq[0].beat));
                if (ready) void'(sbq.pop_front());
            end
        end
    end

    // Spot-check table
    typedef struct {
        int               dut;
        logic [1:0]       op;
        int               beat;
        logic [3:0][31:0] a;
        logic [3:0][31:0] b;
        logic [3:0]       lv;
    } vec_t;
    vec_t tbl[7];

    task automatic run_tbl(input int idx, input vec_t e);
        logic [3:0][31:0] aa, bb;
        logic [3:0] lvv;
        int bt;
        bit vv, dn;
        if (e.dut == 0) begin
            push_expect0(e.op);
            op0 = e.op;
            start0 = 1'b1;
        end else begin
            op1 = e.op;
            start1 = 1'b1;
        end
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (e.beat) @(posedge clk);
        @(negedge clk);
        if (e.dut == 0) begin
            aa = a0; bb = b0; lvv = lv0; bt = int'(beat0); vv = valid0;
        end else begin
            aa = a1; bb = b1; lvv = lv1; bt = int'(beat1); vv = valid1;
        end
        chk($sformatf("tbl%0d_a", idx), 640'(aa), 640'(e.a));
        chk($sformatf("tbl%0d_b", idx), 640'(bb), 640'(e.b));
        chk($sformatf("tbl%0d_lv", idx), 640'(lvv), 640'(e.lv));
        chk($sformatf("tbl%0d_beat", idx), 640'(bt), 640'(e.beat));
        chk($sformatf("tbl%0d_valid", idx), 640'(vv), 640'(1));
        dn = 1'b0;
        for (int k = 0; k < 20 && !dn; k++) begin
            if ((e.dut == 0) ? done0 : done1) dn = 1'b1;
            else @(negedge clk);
        end
        chk($sformatf("tbl%0d_done", idx), 640'(dn), 640'(1));
        $display("table %0d: dut%0d op=%b beat=%0d a=%0h lv=%b", idx, e.dut, e.op, bt, aa, lvv);
        @(posedge clk); #1;
    endtask

    // Full dispatch on instance 0 with optional stall, start pokes and
    // input scrambling; checks done latency against BEATS=5.
    task automatic dispatch0(input string nm, input logic [1:0] op, input int stall_beat,
                             input int stall_n, input bit poke, input bit scramble);
        int t0, got, left;
        bit seen;
        push_expect0(op);
        op0 = op;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        t0 = cyc;
        left = stall_n;
        seen = 1'b0;
        got = -1;
        if (scramble) begin
            for (int i = 0; i < 20; i++) begin
                rd1[i] = 32'hFFFF;
                rd2[i] = 32'hFFFF;
            end
            scalar = 32'hFFFF;
            op0 = ~op;
        end
        for (int k = 0; k < 40 && !seen; k++) begin
            if (valid0 && int'(beat0) == stall_beat && left > 0) begin
                ready = 1'b0;
                left--;
            end else begin
                ready = 1'b1;
            end
            start0 = (poke && valid0 && beat0 == 3'd2) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (done0) begin
                seen = 1'b1;
                got = cyc - t0;
            end else begin
                @(posedge clk); #1;
            end
        end
        chk({nm, "_done_latency"}, 640'(got), 640'(5 + stall_n));
        ready = 1'b1;
        if (poke) start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        chk({nm, "_idle_after_done"}, 640'({busy0, valid0, done0}), 640'(0));
        chk({nm, "_sb_drained"}, 640'(sbq.size()), 640'(0));
        if (scramble) begin
            for (int i = 0; i < 20; i++) begin
                rd1[i] = 32'(i);
                rd2[i] = 32'(100 + i);
            end
            scalar = 32'd7;
        end
        $display("dispatch %s: op=%b stall=%0d done after %0d cycles", nm, op, stall_n, got);
    endtask

    task automatic single_beat(input logic [1:0] op);
        logic [19:0][31:0] expa, expb;
        for (int i = 0; i < 20; i++) begin
            expa[i] = 32'(i);
            expb[i] = op[0] ? 32'(100 + i) : 32'd7;
        end
        op2 = op;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        @(negedge clk);
        chk("u2_a", 640'(a2), 640'(expa));
        chk("u2_b", 640'(b2), 640'(expb));
        chk("u2_lv", 640'(lv2), 640'(20'hFFFFF));
        chk("u2_valid_beat", 640'({valid2, beat2}), 640'(2'b10));
        @(negedge clk);
        chk("u2_done_pulse", 640'({done2, valid2, busy2}), 640'(3'b101));
        @(negedge clk);
        chk("u2_idle", 640'({done2, valid2, busy2}), 640'(0));
        $display("single beat: op=%b lanes valid=%b", op, lv2);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int found;
        bit saw;

        tbl[0] = '{dut: 0, op: 2'b01, beat: 0,
                   a: {32'd15, 32'd10, 32'd5, 32'd0}, b: {32'd115, 32'd110, 32'd105, 32'd100}, lv: 4'b1111};
        tbl[1] = '{dut: 0, op: 2'b01, beat: 4,
                   a: {32'd19, 32'd14, 32'd9, 32'd4}, b: {32'd119, 32'd114, 32'd109, 32'd104}, lv: 4'b1111};
        tbl[2] = '{dut: 0, op: 2'b10, beat: 1,
                   a: {32'd7, 32'd6, 32'd5, 32'd4}, b: {32'd7, 32'd7, 32'd7, 32'd7}, lv: 4'b1111};
        tbl[3] = '{dut: 0, op: 2'b00, beat: 3,
                   a: {32'd18, 32'd13, 32'd8, 32'd3}, b: {32'd7, 32'd7, 32'd7, 32'd7}, lv: 4'b1111};
        tbl[4] = '{dut: 1, op: 2'b01, beat: 2,
                   a: {32'd0, 32'd8, 32'd5, 32'd2}, b: {32'd0, 32'd108, 32'd105, 32'd102}, lv: 4'b0111};
        tbl[5] = '{dut: 1, op: 2'b11, beat: 2,
                   a: {32'd0, 32'd0, 32'd9, 32'd8}, b: {32'd0, 32'd0, 32'd109, 32'd108}, lv: 4'b0011};
        tbl[6] = '{dut: 1, op: 2'b10, beat: 0,
                   a: {32'd3, 32'd2, 32'd1, 32'd0}, b: {32'd7, 32'd7, 32'd7, 32'd7}, lv: 4'b1111};

        RST = 1'b1;
        ready = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        op0 = 2'b00; op1 = 2'b00; op2 = 2'b00;
        scalar = 32'd7;
        for (int i = 0; i < 20; i++) begin
            rd1[i] = 32'(i);
            rd2[i] = 32'(100 + i);
        end
        repeat (3) @(posedge clk);
        #1;
        RST = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_u0_ctrl", 640'({valid0, busy0, done0, lv0, beat0}), 640'(0));
        chk("rst_u0_data", 640'({a0, b0}), 640'(0));
        chk("rst_u1_ctrl", 640'({valid1, busy1, done1, lv1, beat1, a1, b1}), 640'(0));
        chk("rst_u2_ctrl", 640'({valid2, busy2, done2, beat2, lv2}), 640'(0));
        chk("rst_u2_a", 640'(a2), 640'(0));
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_tbl(i, tbl[i]);

        dispatch0("vv_blocked", 2'b01, -1, 0, 1'b0, 1'b0);
        dispatch0("vs_interleaved_scrambled", 2'b10, -1, 0, 1'b0, 1'b1);
        dispatch0("stall_beat1", 2'b01, 1, 3, 1'b0, 1'b0);
        dispatch0("start_pokes", 2'b11, -1, 0, 1'b1, 1'b0);

        // Reset during beat 2 with start held high
        push_expect0(2'b01);
        op0 = 2'b01;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            if (valid0 && beat0 == 3'd2) found = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("rst_reach_beat2", 640'(found), 640'(1));
        RST = 1'b1;
        start0 = 1'b1;
        sbq.delete();
        @(posedge clk); #1;
        RST = 1'b0;
        start0 = 1'b0;
        chk("rst_abort_ctrl", 640'({valid0, busy0, done0, lv0, beat0}), 640'(0));
        chk("rst_abort_data", 640'({a0, b0}), 640'(0));
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done0 || busy0) saw = 1'b1;
        end
        chk("rst_no_done", 640'(saw), 640'(0));
        $display("reset abort: idle after reset, done seen=%0d", saw);
        @(posedge clk); #1;
        dispatch0("after_reset", 2'b01, -1, 0, 1'b0, 1'b0);

        single_beat(2'b01);
        single_beat(2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/vector_lane_dispatcher.md
Name: vector_lane_dispatcher

Overview:
Multi-cycle operand dispatcher that captures two V-element source vectors and a scalar, then issues them to a LANES-wide vector ALU over ceil(V/LANES) beats. It sits between the vector register file read ports and the lane ALUs. It is the parametrised successor of the fixed 4-lane, 20-element fork. It adds a valid/ready handshake, an operand capture stage, a selectable element ordering (blocked or interleaved), ragged-tail masking when V is not a multiple of LANES, and a done pulse.

Parameters:
N, 32, element width in bits
V, 20, elements per vector (V >= 1)
LANES, 4, parallel output lanes (1 <= LANES <= V)
BEATS (derived, not overridable), ceil(V/LANES), number of issue beats
BW (derived), max(1, clog2(BEATS)), beat index width

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous active-high reset
start_i  in  1  request to dispatch; sampled only in IDLE
OpType_i  in  2  bit0: 1=vector-vector, 0=vector-scalar; bit1: 0=blocked order, 1=interleaved order
RD1_VEC_i  in  V x N  source vector A
RD2_VEC_i  in  V x N  source vector B
Scalar_i  in  N  scalar operand for B in vector-scalar mode
ready_i  in  1  downstream accepts the current beat
Vec_A_o  out  LANES x N  lane operands A
Vec_B_o  out  LANES x N  lane operands B
lane_valid_o  out  LANES  per-lane element-present mask
beat_o  out  BW  index of the current beat
valid_o  out  1  beat presented
busy_o  out  1  high in ISSUE and DONE
done_o  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Clocking and reset: single clock CLK; reset RST is synchronous and active-high.
- Reset values: state=IDLE; beat_o=0; valid_o, busy_o, done_o = 0; lane_valid_o=0; Vec_A_o, Vec_B_o = 0; capture registers = 0.
- Reset mid-dispatch aborts immediately: no done_o, and the next cycle is IDLE. RST takes priority over start_i.
- FSM states: IDLE, ISSUE, DONE.
  - IDLE: when start_i=1, latch RD1_VEC_i, RD2_VEC_i, Scalar_i and OpType_i into capture registers, set beat=0, go to ISSUE.
  - ISSUE: valid_o=1.
    - If ready_i=1 and beat<BEATS-1: beat increments.
    - If ready_i=1 and beat==BEATS-1: go to DONE.
    - If ready_i=0: beat and all outputs hold stable.
  - DONE: done_o=1 for exactly one cycle, valid_o=0, then return to IDLE.
  - start_i is ignored outside IDLE.
- Latency: start_i accepted at edge t gives first valid beat in cycle t+1. With ready_i held high, the last beat is in cycle t+BEATS and done_o in cycle t+BEATS+1. A new start_i is accepted in the cycle after done_o.
- Element index e(l, b) for lane l at beat b:
  - blocked: e = l*BEATS + b
  - interleaved: e = b*LANES + l
- Lane mask: lane_valid_o[l] = valid_o && (e < V). Masked lanes drive Vec_A_o[l]=0 and Vec_B_o[l]=0; they never index out of range.
- Operand selection: Vec_A_o[l] = A_cap[e]. Vec_B_o[l] = B_cap[e] if OpType bit0=1, else Scalar_cap, broadcast on all valid lanes.
- Outputs use captured operands only. Source inputs may change after start without affecting the dispatch in flight.
- Outside ISSUE, data outputs, lane_valid_o and beat_o read 0.
- BEATS=1 (LANES>=V): a single beat, then DONE.

Test Plan:
1. V=20, LANES=4, blocked, vector-vector; RD1[i]=i, RD2[i]=100+i; ready_i=1.
   - Beat 0: A={0,5,10,15}, B={100,105,110,115}.
   - Beat 4: A={4,9,14,19}.
   - lane_valid=4'b1111 on all beats; done_o in cycle t+6.
2. Same data, vector-scalar, Scalar=7, interleaved.
   - Beat 1: A={4,5,6,7}, B={7,7,7,7}.
   - Inputs changed to 0xFFFF after start: outputs are unchanged.
3. V=10, LANES=4 (BEATS=3).
   - Blocked, beat 2: A={2,5,8,0}, lane_valid=4'b0111.
   - Interleaved, beat 2: A={8,9,0,0}, lane_valid=4'b0011.
4. Backpressure: ready_i low for 3 cycles during beat 1. valid_o stays high, beat_o=1, outputs stable; done_o is delayed by exactly 3 cycles.
5. RST asserted during beat 2 together with start_i=1. Next cycle: IDLE, all outputs 0, no done_o pulse; a subsequent start_i performs a full 5-beat dispatch.
6. start_i pulsed during ISSUE and during DONE is ignored. LANES=20, V=20: a single beat with all 20 lanes valid, done_o in cycle t+2.
